// File: rtl/axi_lite_mem_ctrl.sv
// AXI4-Lite responder mapping single-word reads/writes onto a CS/WE/ADDR scratch RAM port.
// Optional AXI_MEM_WSTRB_EN enables read-modify-write for partial byte strobes.
module axi_lite_mem_ctrl #(
  parameter int unsigned MEM_AW = 7,
  parameter int unsigned AXI_AW = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AXI_AW-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [AXI_AW-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  localparam int unsigned DW = 32;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_EXEC = 3'd2;
  localparam logic [2:0] S_WR_RESP = 3'd3;
  localparam logic [2:0] S_RD_EXEC = 3'd4;
  localparam logic [2:0] S_RD_RESP = 3'd5;
`ifdef AXI_MEM_WSTRB_EN
  localparam logic [2:0] S_WR_RMW  = 3'd1;
  localparam int unsigned SW = DW / 8;
`endif

  logic [2:0]        state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
`ifdef AXI_MEM_WSTRB_EN
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [DW-1:0]     merged;
`endif

  logic              wr_req, rd_req, grant_wr, grant_rd;
  logic              aw_oor, ar_oor;
  logic [MEM_AW-1:0] aw_idx, ar_idx;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  assign aw_idx = AWADDR[MEM_AW+1:2];
  assign ar_idx = ARADDR[MEM_AW+1:2];
  assign aw_oor = |AWADDR[AXI_AW-1:MEM_AW+2];
  assign ar_oor = |ARADDR[AXI_AW-1:MEM_AW+2];

  // Write needs both AW and W; on contention grant whichever type lost last time.
  assign wr_req   = AWVALID & WVALID;
  assign rd_req   = ARVALID;
  assign grant_wr = (state_q == S_IDLE) & ~RST & wr_req & (~rd_req | ~last_wr_q);
  assign grant_rd = (state_q == S_IDLE) & ~RST & rd_req & ~grant_wr;

  assign AWREADY   = grant_wr;
  assign WREADY    = grant_wr;
  assign ARREADY   = grant_rd;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign RVALID    = rvalid_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;
  assign MEM_CS    = mem_cs_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

`ifdef AXI_MEM_WSTRB_EN
  // Strobed bytes come from the held write data, the rest from the word just read.
  always_comb begin
    merged = MEM_RDATA;
    for (int unsigned i = 0; i < SW; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef AXI_MEM_WSTRB_EN
    wstrb_d     = wstrb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          last_wr_d = 1'b1;
          if (aw_oor) begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end else if (WSTRB == 4'h0) begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
          end else begin
            mem_cs_d    = 1'b1;
            mem_addr_d  = aw_idx;
            mem_wdata_d = WDATA;
`ifdef AXI_MEM_WSTRB_EN
            if (WSTRB != 4'hF) begin
              state_d = S_WR_RMW;
              wstrb_d = WSTRB;
            end else begin
              state_d  = S_WR_EXEC;
              mem_we_d = 1'b1;
            end
`else
            state_d  = S_WR_EXEC;
            mem_we_d = 1'b1;
`endif
          end
        end else if (grant_rd) begin
          last_wr_d = 1'b0;
          if (ar_oor) begin
            state_d  = S_RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
          end else begin
            state_d    = S_RD_EXEC;
            mem_cs_d   = 1'b1;
            mem_addr_d = ar_idx;
          end
        end
      end
`ifdef AXI_MEM_WSTRB_EN
      S_WR_RMW: begin
        state_d     = S_WR_EXEC;
        mem_cs_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_wdata_d = merged;
      end
`endif
      S_WR_EXEC: begin
        state_d  = S_WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
      end
      S_WR_RESP: begin
        if (BREADY) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
        end
      end
      S_RD_EXEC: begin
        state_d  = S_RD_RESP;
        rvalid_d = 1'b1;
        rresp_d  = RESP_OKAY;
        rdata_d  = MEM_RDATA;
      end
      S_RD_RESP: begin
        if (RREADY) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef AXI_MEM_WSTRB_EN
      wstrb_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef AXI_MEM_WSTRB_EN
      wstrb_q     <= wstrb_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_ctrl.sv
// Self-checking bench for axi_lite_mem_ctrl: RAM model on the falling edge, scoreboard of
// expected responses, one task per scenario.
module tb_axi_lite_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA, MEM_WDATA;
  logic [31:0] MEM_RDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, MEM_CS, MEM_WE;
  logic [1:0]  BRESP, RRESP;
  logic [6:0]  MEM_ADDR;

  typedef struct {
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [128];
  logic [31:0] ram [128] = '{default: '0};
  int          wr_cnt = 0, cs_cnt = 0, cyc = 0;
  logic [6:0]  last_wa = '0;
  int          n_cmp = 0, n_fail = 0;

  axi_lite_mem_ctrl #(.MEM_AW(7), .AXI_AW(32)) dut (
    .CLK(CLK), .RST(RST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scratch RAM: commits writes and updates read data on the falling edge.
  always @(negedge CLK) begin
    if (MEM_CS) begin
      if (MEM_WE) begin
        ram[MEM_ADDR] <= MEM_WDATA;
        wr_cnt        <= wr_cnt + 1;
        last_wa       <= MEM_ADDR;
      end else begin
        MEM_RDATA <= ram[MEM_ADDR];
      end
      cs_cnt <= cs_cnt + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a[31:9] != 23'd0;
  endfunction

  function automatic exp_t predict_write(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
    exp_t e;
    logic [31:0] w;
    e.is_wr = 1'b1;
    e.data  = '0;
    e.resp  = 2'b00;
    e.lat   = 1;
    if (oor(a)) begin
      e.resp = 2'b10;
    end else if (s != 4'h0) begin
      w = model[a[8:2]];
`ifdef AXI_MEM_WSTRB_EN
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      e.lat = (s == 4'hF) ? 2 : 3;
`else
      w     = d;
      e.lat = 2;
`endif
      model[a[8:2]] = w;
    end
    return e;
  endfunction

  function automatic exp_t predict_read(input logic [31:0] a);
    exp_t e;
    e.is_wr = 1'b0;
    if (oor(a)) begin
      e.resp = 2'b10;
      e.data = '0;
      e.lat  = 1;
    end else begin
      e.resp = 2'b00;
      e.data = model[a[8:2]];
      e.lat  = 2;
    end
    return e;
  endfunction

  // Latency counts cycles from the handshake cycle to the first cycle with the valid high; -1 on timeout.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    resp = 2'bxx;
    lat  = -1;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    #1;
    n = 0;
    while (!AWREADY && n < 20) begin step(); #1; n++; end
    if (!AWREADY) begin AWVALID = 0; WVALID = 0; return; end
    step();
    AWVALID = 0; WVALID = 0;
    n = 1;
    while (!BVALID && n < 20) begin step(); n++; end
    if (!BVALID) return;
    lat  = n;
    resp = BRESP;
    step();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                         output logic [31:0] data, output int lat);
    int n;
    resp = 2'bxx;
    data = 'x;
    lat  = -1;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin step(); #1; n++; end
    if (!ARREADY) begin ARVALID = 0; return; end
    step();
    ARVALID = 0;
    n = 1;
    while (!RVALID && n < 20) begin step(); n++; end
    if (!RVALID) return;
    lat  = n;
    resp = RRESP;
    data = RDATA;
    step();
  endtask

  task automatic apply_reset();
    RST = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    repeat (2) step();
    RST = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID,
         MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: bvalid=%b rvalid=%b cs=%b we=%b addr=%0h wdata=%0h rdata=%0h, want all 0",
               BVALID, RVALID, MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA);
    end
  endtask

  task automatic test_full_write();
    exp_t e;
    logic [1:0] r;
    logic [31:0] d;
    int lat, w0;
    w0 = wr_cnt;
    sb.push_back(predict_write(32'h0000_0010, 32'hDEADBEEF, 4'hF));
    do_write(32'h0000_0010, 32'hDEADBEEF, 4'hF, r, lat);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e.resp || lat != e.lat) begin
      n_fail++;
      $display("FAIL full_write_resp: bresp=%0h lat=%0d, want bresp=%0h lat=%0d", r, lat, e.resp, e.lat);
    end
    n_cmp++;
    if (wr_cnt - w0 != 1 || last_wa !== 7'd4) begin
      n_fail++;
      $display("FAIL full_write_ram: writes=%0d addr=%0d, want writes=1 addr=4", wr_cnt - w0, last_wa);
    end
    sb.push_back(predict_read(32'h0000_0010));
    do_read(32'h0000_0010, r, d, lat);
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.data || r !== e.resp || lat != e.lat) begin
      n_fail++;
      $display("FAIL full_readback: rdata=%h rresp=%0h lat=%0d, want rdata=%h rresp=%0h lat=%0d",
               d, r, lat, e.data, e.resp, e.lat);
    end
  endtask

  task automatic test_partial_write();
    exp_t e;
    logic [1:0] r;
    logic [31:0] d, want;
    int lat, w0;
`ifdef AXI_MEM_WSTRB_EN
    want = 32'hDE34BE78;
`else
    want = 32'h12345678;
`endif
    sb.push_back(predict_write(32'h0000_0010, 32'h12345678, 4'b0101));
    do_write(32'h0000_0010, 32'h12345678, 4'b0101, r, lat);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e.resp || lat != e.lat) begin
      n_fail++;
      $display("FAIL partial_write_resp: bresp=%0h lat=%0d, want bresp=%0h lat=%0d", r, lat, e.resp, e.lat);
    end
    n_cmp++;
    if (ram[4] !== want) begin
      n_fail++;
      $display("FAIL partial_write_word: ram[4]=%h, want %h", ram[4], want);
    end
    w0 = wr_cnt;
    sb.push_back(predict_write(32'h0000_0010, 32'hFFFF_FFFF, 4'h0));
    do_write(32'h0000_0010, 32'hFFFF_FFFF, 4'h0, r, lat);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e.resp || lat != e.lat || wr_cnt != w0) begin
      n_fail++;
      $display("FAIL zero_strobe_write: bresp=%0h lat=%0d writes=%0d, want bresp=%0h lat=%0d writes=0",
               r, lat, wr_cnt - w0, e.resp, e.lat);
    end
    sb.push_back(predict_read(32'h0000_0013));
    do_read(32'h0000_0013, r, d, lat);
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.data || r !== e.resp || lat != e.lat) begin
      n_fail++;
      $display("FAIL partial_readback: rdata=%h rresp=%0h lat=%0d, want rdata=%h rresp=%0h lat=%0d",
               d, r, lat, e.data, e.resp, e.lat);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [1:0] r;
    logic [31:0] d;
    int lat, c0;
    c0 = cs_cnt;
    sb.push_back(predict_read(32'h0000_0200));
    do_read(32'h0000_0200, r, d, lat);
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.data || r !== e.resp || lat != e.lat || cs_cnt != c0) begin
      n_fail++;
      $display("FAIL oor_read: rdata=%h rresp=%0h lat=%0d cs=%0d, want rdata=%h rresp=%0h lat=%0d cs=0",
               d, r, lat, cs_cnt - c0, e.data, e.resp, e.lat);
    end
    c0 = cs_cnt;
    sb.push_back(predict_write(32'h0000_0200, 32'hCAFEF00D, 4'hF));
    do_write(32'h0000_0200, 32'hCAFEF00D, 4'hF, r, lat);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e.resp || lat != e.lat || cs_cnt != c0) begin
      n_fail++;
      $display("FAIL oor_write: bresp=%0h lat=%0d cs=%0d, want bresp=%0h lat=%0d cs=0",
               r, lat, cs_cnt - c0, e.resp, e.lat);
    end
    n_cmp++;
    if (ram[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_write_alias: ram[0]=%h, want 0", ram[0]);
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    logic [1:0] want_g;
    int n;
    apply_reset();
    BREADY = 1; RREADY = 1;
    for (int i = 0; i < 4; i++) begin
      AWADDR = 32'h20; WDATA = 32'hA5A5_0000 | i; WSTRB = 4'hF; ARADDR = 32'h20;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      #1;
      n = 0;
      while (!AWREADY && !ARREADY && n < 20) begin step(); #1; n++; end
      want_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({AWREADY, ARREADY} !== want_g) begin
        n_fail++;
        $display("FAIL arb_grant_%0d: {awready,arready}=%b, want %b", i, {AWREADY, ARREADY}, want_g);
      end
      if (AWREADY) sb.push_back(predict_write(32'h20, 32'hA5A5_0000 | i, 4'hF));
      else         sb.push_back(predict_read(32'h20));
      step();
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      n = 0;
      while (!BVALID && !RVALID && n < 20) begin step(); n++; end
      e = sb.pop_front();
      n_cmp++;
      if (e.is_wr ? (BVALID !== 1'b1 || BRESP !== e.resp)
                  : (RVALID !== 1'b1 || RRESP !== e.resp || RDATA !== e.data)) begin
        n_fail++;
        $display("FAIL arb_resp_%0d: bvalid=%b rvalid=%b rdata=%h, want %s resp data=%h",
                 i, BVALID, RVALID, RDATA, e.is_wr ? "write" : "read", e.data);
      end
      step();
    end
  endtask

  task automatic test_rready_stall();
    exp_t e;
    int n;
    sb.push_back(predict_read(32'h10));
    ARADDR = 32'h10; ARVALID = 1; RREADY = 0;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin step(); #1; n++; end
    step();
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (RVALID !== 1'b1 || RDATA !== e.data || RRESP !== e.resp || ARREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rvalid=%b rdata=%h rresp=%0h arready=%b, want 1 %h %0h 0",
                 k, RVALID, RDATA, RRESP, ARREADY, e.data, e.resp);
      end
      step();
    end
    RREADY = 1;
    #1;
    n_cmp++;
    if (ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early_ready: arready=%b while rready rises, want 0", ARREADY);
    end
    step();
    n_cmp++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: arready=%b rvalid=%b, want arready=1 rvalid=0", ARREADY, RVALID);
    end
    sb.push_back(predict_read(32'h10));
    step();
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    e = sb.pop_front();
    n_cmp++;
    if (RVALID !== 1'b1 || RDATA !== e.data) begin
      n_fail++;
      $display("FAIL stall_second_read: rvalid=%b rdata=%h, want 1 %h", RVALID, RDATA, e.data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int t [3];
    int n;
    ARADDR = 32'h10; ARVALID = 1; RREADY = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n = 0;
      while (!ARREADY && n < 20) begin step(); #1; n++; end
      step();
      t[k] = cyc;
    end
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    step();
    for (int k = 1; k < 3; k++) begin
      n_cmp++;
      if (t[k] - t[k-1] != 3) begin
        n_fail++;
        $display("FAIL b2b_period_%0d: %0d cycles between handshakes, want 3", k, t[k] - t[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    bit seen;
    ARADDR = 32'h10; ARVALID = 1; RREADY = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin step(); #1; n++; end
    step();
    ARVALID = 0;
    n_cmp++;
    if (MEM_CS !== 1'b1 || MEM_WE !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_exec: cs=%b we=%b, want cs=1 we=0", MEM_CS, MEM_WE);
    end
    RST = 1;
    step();
    RST = 0;
    n_cmp++;
    if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID,
         MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA} !== '0) begin
      n_fail++;
      $display("FAIL mid_read_reset: rvalid=%b cs=%b addr=%0h rdata=%h, want all 0",
               RVALID, MEM_CS, MEM_ADDR, RDATA);
    end
    seen = 0;
    repeat (6) begin step(); if (RVALID) seen = 1; end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_read_dropped: rvalid seen=%b after reset, want 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) model[i] = '0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_out_of_range();
    test_arbitration();
    test_rready_stall();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_mem_ctrl.md
# axi_lite_mem_ctrl

AXI4-Lite responder that turns bus read/write transactions into single-word accesses on the 128×32 scratch RAM's CS/WE/ADDR port. Sits between the AXI-Lite interconnect and the RAM, which it drives as initiator. The RAM commits writes and updates its read data on the falling clock edge. One transaction is in flight at a time.

## Interface
- `MEM_AW`, 7: RAM word-address width (depth 2^MEM_AW).
- `AXI_AW`, 32: AXI byte-address width.
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `AWADDR` in AXI_AW, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in 32, `WSTRB` in 4, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARADDR` in AXI_AW, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out 32, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel.
- `MEM_CS` out 1, `MEM_WE` out 1, `MEM_ADDR` out MEM_AW, `MEM_WDATA` out 32: registered RAM controls.
- `MEM_RDATA` in 32: RAM read data, valid after the falling edge following MEM_ADDR.

## Operation
- States: IDLE, WR_RMW, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP.
- IDLE:
  - A write is ready when AWVALID and WVALID are both high.
  - A read is ready when ARVALID is high.
  - AWREADY and WREADY assert together, combinationally, only for a granted write.
  - ARREADY asserts combinationally only for a granted read.
- Arbitration: when both are ready, grant the type not granted last. After reset, write wins.
- Address decode:
  - Word index = addr[MEM_AW+1:2]; addr[1:0] is ignored.
  - addr[AXI_AW-1:MEM_AW+2] != 0 means out of range.
- Out-of-range access:
  - No RAM cycle occurs.
  - Go directly to WR_RESP or RD_RESP with response 2'b10 (SLVERR). RDATA = 0.
- Write, WSTRB == 4'hF: handshake → WR_EXEC with MEM_CS=1, MEM_WE=1 for exactly one cycle → WR_RESP.
- Write, WSTRB == 0: no RAM cycle; go to WR_RESP with OKAY.
- Other WSTRB values: see Configuration.
- Read: handshake → RD_EXEC with MEM_CS=1, MEM_WE=0 for one cycle. RDATA captures MEM_RDATA at the end of RD_EXEC → RD_RESP.
- WR_RESP:
  - BVALID=1, held with BRESP stable until BREADY.
  - Return to IDLE on the cycle after the BVALID&BREADY edge; BVALID drops on that edge.
- RD_RESP: same rules with RVALID/RREADY; RDATA and RRESP held stable.
- Responses are 2'b00 (OKAY) unless out of range.
- MEM_CS and MEM_WE are 0 in every state other than WR_RMW, WR_EXEC and RD_EXEC. MEM_WE is 1 only in WR_EXEC.
- MEM_ADDR and MEM_WDATA hold their last value while idle.

## Timing
- Reset value of every output is 0. State returns to IDLE and the arbitration pointer resets to write-first.
- Reset mid-transaction: the transaction is dropped, no response is issued, and MEM_CS deasserts on the next edge.
- Write latency, handshake edge to BVALID high:
  - 2 cycles for a full write.
  - 3 cycles for an RMW write.
  - 1 cycle for WSTRB=0 or out of range.
- Read latency, handshake edge to RVALID high: 2 cycles, or 1 cycle out of range.
- Back-to-back: a new handshake can occur in the first IDLE cycle after the response handshake. Sustained throughput is 1 transaction per 3 cycles with zero-wait ready.
- AW without W, or W without AW, is not accepted. Neither ready asserts and the channels wait.

## Configuration
- `AXI_MEM_WSTRB_EN` defined, partial WSTRB (not 0, not F) uses read-modify-write:
  - WR_RMW reads the word (MEM_CS=1, MEM_WE=0).
  - MEM_WDATA is the byte-wise merge of WDATA into MEM_RDATA per WSTRB.
  - Then WR_EXEC writes it.
- `AXI_MEM_WSTRB_EN` undefined:
  - WR_RMW is absent.
  - Any nonzero WSTRB writes the full WDATA word.

## Test plan
- Write 0x0000_0010 ← 0xDEADBEEF, WSTRB=F, BREADY=1 → exactly one MEM_CS&MEM_WE cycle with MEM_ADDR=4; BVALID 2 cycles after handshake; BRESP=0. Then read 0x10 → RDATA=0xDEADBEEF, RRESP=0, RVALID 2 cycles after handshake.
- With the macro defined, word 4 = 0xDEADBEEF, write 0x12345678 with WSTRB=4'b0101 → RAM word = 0xDE34BE78, BVALID 3 cycles after handshake. Without the macro → word = 0x12345678, 2 cycles.
- Read 0x0000_0200 → no MEM_CS; RVALID next cycle, RRESP=2'b10, RDATA=0. Same for a write, with BRESP=2'b10 and the RAM unchanged.
- AW, W and AR all valid at once after reset → write granted first, then the read. Repeated simultaneous requests alternate write/read.
- Hold RREADY low 5 cycles → RVALID and RDATA stable throughout. No new handshake until 1 cycle after RREADY rises.
- Assert RST during RD_EXEC → next cycle all outputs 0, state IDLE, no RVALID ever issued for the dropped read.
